// File: rtl/alu_pkg.sv
// Shared types for the 4-bit ALU issue path: widths, instruction word, issue FSM states.
// Pure declarations; no logic and no timing of its own.
package alu_pkg;

  localparam int OPW = 3;
  localparam int DW  = 4;

  typedef logic [OPW-1:0] opcode_t;

  typedef struct packed {
    opcode_t        opcode;
    logic [DW-1:0]  op1;
    logic [DW-1:0]  op2;
  } alu_instr_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_STALL = 2'd2
  } issue_state_t;

endpackage

// File: rtl/alu_issue_fifo.sv
// In-order DEPTH-entry instruction FIFO; head is visible combinationally, write lands next cycle.
// The caller must not write when full or read when empty; flush empties it in one cycle.
module alu_issue_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         wr_vld,
  input  alu_instr_t                   wr_dat,
  input  logic                         rd_en,
  output alu_instr_t                   rd_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  alu_instr_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally
      if (wr_vld) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (rd_en)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({wr_vld, rd_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld) r_mem[r_wr_ptr] <= wr_dat;
  end

  assign rd_dat = r_mem[r_rd_ptr];
  assign count  = r_count;
  assign empty  = (r_count == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn || flush)
    !(wr_vld && !rd_en && r_count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rstn || flush)
    !(rd_en && r_count == '0));

endmodule

// File: rtl/alu_issue_stage.sv
// FIFO-buffered issue stage to the ALU: latency 2 (1 with ALU_ISSUE_BYPASS_EN defined).
// in_ready = FIFO not full (registered only); output regs hold steady while out_ready is low.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OPW-1:0]               in_opcode,
  input  logic [DW-1:0]                in_op1,
  input  logic [DW-1:0]                in_op2,
  output logic [OPW-1:0]               OPCODE,
  output logic [DW-1:0]                OP1,
  output logic [DW-1:0]                OP2,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(DEPTH+1);

  issue_state_t  r_state;
  issue_state_t  w_state_nxt;
  alu_instr_t    r_instr;
  alu_instr_t    w_in_instr;
  alu_instr_t    w_fifo_head;
  alu_instr_t    w_load_dat;
  logic [CW-1:0] w_count;
  logic          w_fifo_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_stage_free;
  logic          w_bypass;
  logic          w_fifo_wr;
  logic          w_fifo_rd;
  logic          w_load;

  assign w_in_instr   = '{opcode: in_opcode, op1: in_op1, op2: in_op2};
  assign in_ready     = (w_count != CW'(DEPTH));
  assign w_push       = in_valid & in_ready;
  assign w_pop        = out_valid & out_ready;
  assign w_stage_free = ~out_valid | w_pop;

`ifdef ALU_ISSUE_BYPASS_EN
  assign w_bypass = w_stage_free & w_fifo_empty & w_push & ~flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_fifo_wr  = w_push & ~w_bypass & ~flush;
  assign w_fifo_rd  = w_stage_free & ~w_fifo_empty & ~flush;
  assign w_load     = w_fifo_rd | w_bypass;
  assign w_load_dat = w_bypass ? w_in_instr : w_fifo_head;

  alu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .flush  (flush),
    .wr_vld (w_fifo_wr),
    .wr_dat (w_in_instr),
    .rd_en  (w_fifo_rd),
    .rd_dat (w_fifo_head),
    .count  (w_count),
    .empty  (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:           if (w_load) w_state_nxt = S_ISSUE;
        S_ISSUE, S_STALL: if (!out_ready)  w_state_nxt = S_STALL;
                          else if (w_load) w_state_nxt = S_ISSUE;
                          else             w_state_nxt = S_IDLE;
        default:          w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_valid = (r_state != S_IDLE);
  end

  // Data keeps its last value when the stage empties; only reset clears it
  always_ff @(posedge clk) begin
    if (!rstn)       r_instr <= '0;
    else if (w_load) r_instr <= w_load_dat;
  end

  assign OPCODE     = r_instr.opcode;
  assign OP1        = r_instr.op1;
  assign OP2        = r_instr.op2;
  assign fifo_count = w_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage (default build, FIFO latency 2, DEPTH=4).
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic           clk = 1'b0;
  logic           rstn;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_opcode;
  logic [DW-1:0]  in_op1;
  logic [DW-1:0]  in_op2;
  logic [OPW-1:0] OPCODE;
  logic [DW-1:0]  OP1;
  logic [DW-1:0]  OP2;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_stage #(.DEPTH(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .OPCODE     (OPCODE),
    .OP1        (OP1),
    .OP2        (OP2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] opc, input logic [3:0] a, input logic [3:0] b);
    in_valid  = v;
    in_opcode = opc;
    in_op1    = a;
    in_op2    = b;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] opc, input logic [3:0] a, input logic [3:0] b);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_opc"}, 32'(OPCODE), 32'(opc));
    chk({tag, "_op1"}, 32'(OP1), 32'(a));
    chk({tag, "_op2"}, 32'(OP2), 32'(b));
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    tick(); tick();
    chk("rst_vld",   32'(out_valid),  32'd0);
    chk("rst_opc",   32'(OPCODE),     32'd0);
    chk("rst_op1",   32'(OP1),        32'd0);
    chk("rst_op2",   32'(OP2),        32'd0);
    chk("rst_cnt",   32'(fifo_count), 32'd0);
    chk("rst_rdy",   32'(in_ready),   32'd1);
    rstn = 1'b1;

    // single op, latency 2
    out_ready = 1'b1;
    drive(1'b1, 3'd7, 4'hF, 4'h0);
    tick();
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    chk("lat_n1_vld", 32'(out_valid),  32'd0);
    chk("lat_n1_cnt", 32'(fifo_count), 32'd1);
    tick();
    chk_out("lat_n2", 3'd7, 4'hF, 4'h0);
    chk("lat_n2_cnt", 32'(fifo_count), 32'd0);
    tick();
    chk("pop_empty_vld", 32'(out_valid), 32'd0);

    // fill with out_ready low: ops {i+1, A+i, i}
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'(i + 1), 4'(10 + i), 4'(i));
      tick();
    end
    chk_out("fill_head", 3'd1, 4'hA, 4'h0);
    chk("fill_cnt", 32'(fifo_count), 32'd4);
    chk("fill_rdy", 32'(in_ready),   32'd0);
    drive(1'b1, 3'd6, 4'hE, 4'hE);
    tick();
    chk("full_rej_cnt", 32'(fifo_count), 32'd4);
    chk("full_rej_rdy", 32'(in_ready),   32'd0);
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk_out("drain", 3'(i + 1), 4'(10 + i), 4'(i));
      chk("drain_cnt", 32'(fifo_count), 32'(4 - i));
    end
    tick();
    chk("drain_end_vld", 32'(out_valid), 32'd0);

    // stall hold
    out_ready = 1'b0;
    drive(1'b1, 3'd3, 4'd2, 4'd1);
    tick();
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("stall", 3'd3, 4'd2, 4'd1);
      chk("stall_fsm", 32'(dut.r_state), 32'(S_STALL));
    end

    // fill behind the stalled op, then push+pop while full
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(4 + i), 4'(i), 4'(15 - i));
      tick();
    end
    chk("full2_cnt", 32'(fifo_count), 32'd4);
    chk("full2_rdy", 32'(in_ready),   32'd0);
    drive(1'b1, 3'd7, 4'd7, 4'd7);
    out_ready = 1'b1;
    tick();
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    out_ready = 1'b0;
    chk("fullpp_cnt", 32'(fifo_count), 32'd3);
    chk("fullpp_rdy", 32'(in_ready),   32'd1);
    chk_out("fullpp", 3'd4, 4'd0, 4'd15);

    // flush with count=3 and a push in the same cycle
    flush = 1'b1;
    drive(1'b1, 3'd2, 4'd9, 4'd9);
    tick();
    flush = 1'b0;
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    chk("flush_cnt", 32'(fifo_count), 32'd0);
    chk("flush_vld", 32'(out_valid),  32'd0);
    chk("flush_rdy", 32'(in_ready),   32'd1);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("flush_drop_vld", 32'(out_valid),  32'd0);
    chk("flush_drop_cnt", 32'(fifo_count), 32'd0);

    // reset in the middle of a drain
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 4'd1, 4'd1); tick();
    drive(1'b1, 3'd2, 4'd2, 4'd2); tick();
    drive(1'b1, 3'd5, 4'd6, 4'd7); tick();
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    chk_out("pre_rst", 3'd1, 4'd1, 4'd1);
    chk("pre_rst_cnt", 32'(fifo_count), 32'd2);
    out_ready = 1'b1;
    tick();
    chk_out("mid_drain", 3'd2, 4'd2, 4'd2);
    chk("mid_drain_cnt", 32'(fifo_count), 32'd1);
    rstn = 1'b0;
    tick();
    chk("mrst_vld", 32'(out_valid),  32'd0);
    chk("mrst_opc", 32'(OPCODE),     32'd0);
    chk("mrst_op1", 32'(OP1),        32'd0);
    chk("mrst_op2", 32'(OP2),        32'd0);
    chk("mrst_cnt", 32'(fifo_count), 32'd0);
    chk("mrst_rdy", 32'(in_ready),   32'd1);
    rstn = 1'b1;
    tick(); tick();
    chk("mrst_drop_vld", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
